// File: rtl/ysyx_25040111_axi_sram.sv
// AXI4 responder memory: independent read/write FSMs, one outstanding burst per channel,
// byte-lane block RAM with registered read, FIXED/INCR bursts and per-beat range checking.
module ysyx_25040111_axi_sram #(
    parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
    parameter int          MEM_AW    = 12,
    parameter int          RD_LAT    = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        s_awready,
    input  logic        s_awvalid,
    input  logic [31:0] s_awaddr,
    input  logic [3:0]  s_awid,
    input  logic [7:0]  s_awlen,
    input  logic [2:0]  s_awsize,
    input  logic [1:0]  s_awburst,
    output logic        s_wready,
    input  logic        s_wvalid,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wlast,
    input  logic        s_bready,
    output logic        s_bvalid,
    output logic [1:0]  s_bresp,
    output logic [3:0]  s_bid,
    output logic        s_arready,
    input  logic        s_arvalid,
    input  logic [31:0] s_araddr,
    input  logic [3:0]  s_arid,
    input  logic [7:0]  s_arlen,
    input  logic [2:0]  s_arsize,
    input  logic [1:0]  s_arburst,
    input  logic        s_rready,
    output logic        s_rvalid,
    output logic [1:0]  s_rresp,
    output logic [31:0] s_rdata,
    output logic        s_rlast,
    output logic [3:0]  s_rid
);
    localparam int          DEPTH = 1 << MEM_AW;
    localparam logic [32:0] SPAN  = 33'd4 << MEM_AW;

    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_DATA  = 2'd1;
    localparam logic [1:0] W_RESP  = 2'd2;
    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_WAIT  = 2'd1;
    localparam logic [1:0] R_BURST = 2'd2;

    function automatic logic in_range(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - ADDR_BASE;
        return {1'b0, off} < SPAN;
    endfunction

    function automatic logic [MEM_AW-1:0] word_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - ADDR_BASE;
        return off[MEM_AW+1:2];
    endfunction

    function automatic logic legal(input logic [1:0] burst, input logic [2:0] size);
        return (burst == 2'b00 || burst == 2'b01) && size <= 3'd2;
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst);
        return (burst == 2'b01) ? addr + 32'd4 : addr;
    endfunction

    // ---------------- write channel ----------------
    logic [1:0]  w_state_reg;
    logic [3:0]  aw_id_reg;
    logic [31:0] aw_addr_reg;
    logic [7:0]  aw_len_reg;
    logic [1:0]  aw_burst_reg;
    logic        aw_legal_reg;
    logic [7:0]  w_cnt_reg;
    logic        w_err_reg;
    logic [1:0]  bresp_reg;
    logic        w_beat_last;
    logic        w_beat_ok;
    logic        w_err_next;
    logic        w_we;
    logic [MEM_AW-1:0] w_idx;

    assign w_beat_last = (w_cnt_reg == aw_len_reg);
    assign w_beat_ok   = aw_legal_reg && in_range(aw_addr_reg);
    // A wlast that disagrees with the beat count poisons the response but does not drop data.
    assign w_err_next  = w_err_reg || !w_beat_ok || (s_wlast != w_beat_last);
    assign w_we        = !reset && (w_state_reg == W_DATA) && s_wvalid && w_beat_ok;
    assign w_idx       = word_idx(aw_addr_reg);

    always_ff @(posedge clock) begin
        if (reset) begin
            w_state_reg  <= W_IDLE;
            aw_id_reg    <= 4'd0;
            aw_addr_reg  <= 32'd0;
            aw_len_reg   <= 8'd0;
            aw_burst_reg <= 2'd0;
            aw_legal_reg <= 1'b0;
            w_cnt_reg    <= 8'd0;
            w_err_reg    <= 1'b0;
            bresp_reg    <= 2'd0;
        end else begin
            case (w_state_reg)
                W_IDLE: if (s_awvalid) begin
                    aw_id_reg    <= s_awid;
                    aw_addr_reg  <= s_awaddr;
                    aw_len_reg   <= s_awlen;
                    aw_burst_reg <= s_awburst;
                    aw_legal_reg <= legal(s_awburst, s_awsize);
                    w_cnt_reg    <= 8'd0;
                    w_err_reg    <= 1'b0;
                    w_state_reg  <= W_DATA;
                end
                W_DATA: if (s_wvalid) begin
                    aw_addr_reg <= next_addr(aw_addr_reg, aw_burst_reg);
                    w_cnt_reg   <= w_cnt_reg + 8'd1;
                    w_err_reg   <= w_err_next;
                    if (w_beat_last) begin
                        bresp_reg   <= w_err_next ? 2'b10 : 2'b00;
                        w_state_reg <= W_RESP;
                    end
                end
                W_RESP: if (s_bready) w_state_reg <= W_IDLE;
                default: w_state_reg <= W_IDLE;
            endcase
        end
    end

    assign s_awready = (w_state_reg == W_IDLE);
    assign s_wready  = (w_state_reg == W_DATA);
    assign s_bvalid  = (w_state_reg == W_RESP);
    assign s_bresp   = bresp_reg;
    assign s_bid     = aw_id_reg;

    // ---------------- read channel ----------------
    logic [1:0]  r_state_reg;
    logic [3:0]  ar_id_reg;
    logic [31:0] ar_addr_reg;
    logic [7:0]  ar_len_reg;
    logic [1:0]  ar_burst_reg;
    logic        ar_legal_reg;
    logic [7:0]  r_cnt_reg;
    logic [3:0]  r_lat_reg;
    logic [1:0]  rresp_reg;
    logic        rlast_reg;
    logic        rd_load;
    logic [31:0] rd_addr;
    logic        rd_legal;
    logic        rd_last;
    logic        rd_ok;
    logic [MEM_AW-1:0] rd_idx;
    logic [31:0] rdata_w;

    // rd_load marks the edge at which a new beat (data, resp, last) is captured.
    always_comb begin
        rd_load  = 1'b0;
        rd_addr  = ar_addr_reg;
        rd_legal = ar_legal_reg;
        rd_last  = 1'b0;
        case (r_state_reg)
            R_IDLE: if (s_arvalid && (RD_LAT == 0)) begin
                rd_load  = 1'b1;
                rd_addr  = s_araddr;
                rd_legal = legal(s_arburst, s_arsize);
                rd_last  = (s_arlen == 8'd0);
            end
            R_WAIT: if (r_lat_reg == 4'd0) begin
                rd_load = 1'b1;
                rd_last = (ar_len_reg == 8'd0);
            end
            R_BURST: if (s_rready && !rlast_reg) begin
                rd_load = 1'b1;
                rd_addr = next_addr(ar_addr_reg, ar_burst_reg);
                rd_last = ((r_cnt_reg + 8'd1) == ar_len_reg);
            end
            default: ;
        endcase
    end

    assign rd_ok  = rd_legal && in_range(rd_addr);
    assign rd_idx = word_idx(rd_addr);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_reg  <= R_IDLE;
            ar_id_reg    <= 4'd0;
            ar_addr_reg  <= 32'd0;
            ar_len_reg   <= 8'd0;
            ar_burst_reg <= 2'd0;
            ar_legal_reg <= 1'b0;
            r_cnt_reg    <= 8'd0;
            r_lat_reg    <= 4'd0;
            rresp_reg    <= 2'd0;
            rlast_reg    <= 1'b0;
        end else begin
            case (r_state_reg)
                R_IDLE: if (s_arvalid) begin
                    ar_id_reg    <= s_arid;
                    ar_addr_reg  <= s_araddr;
                    ar_len_reg   <= s_arlen;
                    ar_burst_reg <= s_arburst;
                    ar_legal_reg <= legal(s_arburst, s_arsize);
                    r_cnt_reg    <= 8'd0;
                    // Loaded one short so that exactly RD_LAT idle cycles precede rvalid.
                    r_lat_reg    <= 4'(RD_LAT - 1);
                    r_state_reg  <= (RD_LAT == 0) ? R_BURST : R_WAIT;
                end
                R_WAIT: if (r_lat_reg == 4'd0) r_state_reg <= R_BURST;
                        else r_lat_reg <= r_lat_reg - 4'd1;
                R_BURST: if (s_rready) begin
                    if (rlast_reg) begin
                        r_state_reg <= R_IDLE;
                    end else begin
                        ar_addr_reg <= rd_addr;
                        r_cnt_reg   <= r_cnt_reg + 8'd1;
                    end
                end
                default: r_state_reg <= R_IDLE;
            endcase
            if (rd_load) begin
                rresp_reg <= rd_ok ? 2'b00 : 2'b10;
                rlast_reg <= rd_last;
            end else if (r_state_reg == R_BURST && s_rready && rlast_reg) begin
                rlast_reg <= 1'b0;
            end
        end
    end

    // One byte-wide RAM per lane; a same-cycle write is not visible to the read register.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] q_reg;
            always_ff @(posedge clock) begin
                if (w_we && s_wstrb[gi]) mem[w_idx] <= s_wdata[gi*8 +: 8];
            end
            always_ff @(posedge clock) begin
                if (reset) q_reg <= 8'h00;
                else if (rd_load) q_reg <= rd_ok ? mem[rd_idx] : 8'h00;
            end
            assign rdata_w[gi*8 +: 8] = q_reg;
        end
    endgenerate

    assign s_arready = (r_state_reg == R_IDLE);
    assign s_rvalid  = (r_state_reg == R_BURST);
    assign s_rresp   = rresp_reg;
    assign s_rdata   = rdata_w;
    assign s_rlast   = rlast_reg;
    assign s_rid     = ar_id_reg;
endmodule

// File: tb/tb_ysyx_25040111_axi_sram.sv
// Directed bench for the AXI SRAM: a word-level memory model predicts B responses and R beats.
module tb_ysyx_25040111_axi_sram;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int AW  = 12;
    localparam int LAT = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        s_awready, s_awvalid;
    logic [31:0] s_awaddr;
    logic [3:0]  s_awid;
    logic [7:0]  s_awlen;
    logic [2:0]  s_awsize;
    logic [1:0]  s_awburst;
    logic        s_wready, s_wvalid, s_wlast;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_bready, s_bvalid;
    logic [1:0]  s_bresp;
    logic [3:0]  s_bid;
    logic        s_arready, s_arvalid;
    logic [31:0] s_araddr;
    logic [3:0]  s_arid;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst;
    logic        s_rready, s_rvalid, s_rlast;
    logic [1:0]  s_rresp;
    logic [31:0] s_rdata;
    logic [3:0]  s_rid;

    always #5 clock = ~clock;

    ysyx_25040111_axi_sram #(.ADDR_BASE(BASE), .MEM_AW(AW), .RD_LAT(LAT)) dut (
        .clock(clock), .reset(reset),
        .s_awready(s_awready), .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awid(s_awid),
        .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
        .s_wready(s_wready), .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_wlast(s_wlast),
        .s_bready(s_bready), .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bid(s_bid),
        .s_arready(s_arready), .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arid(s_arid),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_rready(s_rready), .s_rvalid(s_rvalid), .s_rresp(s_rresp), .s_rdata(s_rdata),
        .s_rlast(s_rlast), .s_rid(s_rid)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_mem [int unsigned];
    beat_t       exp_q [$];
    logic [3:0]  exp_rid = 4'd0;
    int          r_popped = 0;
    logic [31:0] last_rdata = 32'd0;
    logic [1:0]  last_bresp = 2'd0;
    logic [31:0] wd_v [16];
    logic [3:0]  ws_v [16];
    logic        wl_v [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic beat_ok(input logic [31:0] addr, input logic [1:0] burst,
                                     input logic [2:0] size);
        logic [31:0] off;
        off = addr - BASE;
        return (burst < 2'd2) && (size <= 3'd2) && (off < (32'd4 << AW));
    endfunction

    // R-channel compare: every cycle rvalid is high the front of exp_q must be on the bus.
    always @(negedge clock) begin
        if (!reset && s_rvalid) begin
            if (exp_q.size() == 0) begin
                check("r_unexpected_beat", 32'(s_rvalid), 32'd0);
            end else begin
                check("rdata", s_rdata, exp_q[0].data);
                check("rresp", 32'(s_rresp), 32'(exp_q[0].resp));
                check("rlast", 32'(s_rlast), 32'(exp_q[0].last));
                check("rid", 32'(s_rid), 32'(exp_rid));
                if (s_rready) begin
                    last_rdata = s_rdata;
                    void'(exp_q.pop_front());
                    r_popped++;
                end
            end
        end
    end

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
        logic        err;
        logic [31:0] a;
        logic [31:0] word;
        int unsigned idx;
        int          guard;
        err = 1'b0;
        a = addr;
        for (int b = 0; b <= int'(len); b++) begin
            if (!beat_ok(a, burst, size)) begin
                err = 1'b1;
            end else begin
                idx = (a - BASE) >> 2;
                word = model_mem.exists(idx) ? model_mem[idx] : 32'd0;
                for (int k = 0; k < 4; k++)
                    if (ws_v[b][k]) word[k*8 +: 8] = wd_v[b][k*8 +: 8];
                model_mem[idx] = word;
            end
            if (wl_v[b] != (b == int'(len))) err = 1'b1;
            if (burst == 2'b01) a = a + 32'd4;
        end
        s_awvalid = 1'b1; s_awid = id; s_awaddr = addr; s_awlen = len;
        s_awsize = size; s_awburst = burst;
        s_wvalid = 1'b1; s_wdata = wd_v[0]; s_wstrb = ws_v[0]; s_wlast = wl_v[0];
        guard = 0;
        @(negedge clock);
        check("w_stalled_before_aw", 32'(s_wready), 32'd0);
        while (!s_awready && guard < 50) begin @(negedge clock); guard++; end
        check("aw_handshake_timeout", 32'(guard < 50), 32'd1);
        @(posedge clock); #1;
        s_awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            s_wvalid = 1'b1; s_wdata = wd_v[b]; s_wstrb = ws_v[b]; s_wlast = wl_v[b];
            guard = 0;
            @(negedge clock);
            while (!s_wready && guard < 50) begin @(negedge clock); guard++; end
            if (guard >= 50) check("w_handshake_timeout", 32'(guard), 32'd0);
            @(posedge clock); #1;
        end
        s_wvalid = 1'b0; s_wlast = 1'b0; s_bready = 1'b1;
        @(negedge clock);
        check("bvalid_after_last_w", 32'(s_bvalid), 32'd1);
        check("bresp", 32'(s_bresp), err ? 32'd2 : 32'd0);
        check("bid", 32'(s_bid), 32'(id));
        last_bresp = s_bresp;
        @(posedge clock); #1;
        s_bready = 1'b0;
        @(negedge clock);
        check("bvalid_clear_after_b", 32'(s_bvalid), 32'd0);
        check("awready_after_b", 32'(s_awready), 32'd1);
        @(posedge clock); #1;
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input bit toggle,
                            input int abort_at);
        logic [31:0] a;
        int unsigned idx;
        beat_t       bt;
        int          guard, lat, k, n;
        bit          aborted;
        a = addr;
        exp_q.delete();
        for (int b = 0; b <= int'(len); b++) begin
            idx = (a - BASE) >> 2;
            if (beat_ok(a, burst, size)) begin
                bt.data = model_mem.exists(idx) ? model_mem[idx] : 32'd0;
                bt.resp = 2'b00;
            end else begin
                bt.data = 32'd0;
                bt.resp = 2'b10;
            end
            bt.last = (b == int'(len));
            exp_q.push_back(bt);
            if (burst == 2'b01) a = a + 32'd4;
        end
        n = int'(len) + 1;
        exp_rid = id;
        r_popped = 0;
        aborted = 1'b0;
        s_arvalid = 1'b1; s_arid = id; s_araddr = addr; s_arlen = len;
        s_arsize = size; s_arburst = burst; s_rready = 1'b0;
        guard = 0;
        @(negedge clock);
        while (!s_arready && guard < 50) begin @(negedge clock); guard++; end
        check("ar_handshake_timeout", 32'(guard < 50), 32'd1);
        @(posedge clock); #1;
        s_arvalid = 1'b0;
        s_rready = !toggle;
        lat = 1;
        @(negedge clock);
        while (!s_rvalid && lat < 40) begin @(negedge clock); lat++; end
        check("r_first_latency", 32'(lat), 32'(LAT + 1));
        k = 0;
        guard = 0;
        while (guard < 200) begin
            @(posedge clock); #1;
            if (r_popped >= n) break;
            if (abort_at >= 0 && r_popped == abort_at) begin aborted = 1'b1; break; end
            s_rready = toggle ? (k % 2 == 0) : 1'b1;
            k++;
            guard++;
        end
        check("r_burst_timeout", 32'(r_popped >= n || aborted), 32'd1);
        s_rready = 1'b0;
        if (aborted) begin
            reset = 1'b1;
            exp_q.delete();
            @(posedge clock); #1;
            reset = 1'b0;
            @(negedge clock);
            check("abort_rvalid", 32'(s_rvalid), 32'd0);
            check("abort_arready", 32'(s_arready), 32'd1);
            check("abort_awready", 32'(s_awready), 32'd1);
        end else begin
            @(negedge clock);
            check("rvalid_clear_after_last", 32'(s_rvalid), 32'd0);
            check("arready_after_last", 32'(s_arready), 32'd1);
        end
        @(posedge clock); #1;
    endtask

    initial begin
        s_awvalid = 0; s_awaddr = 0; s_awid = 0; s_awlen = 0; s_awsize = 0; s_awburst = 0;
        s_wvalid = 0; s_wdata = 0; s_wstrb = 0; s_wlast = 0; s_bready = 0;
        s_arvalid = 0; s_araddr = 0; s_arid = 0; s_arlen = 0; s_arsize = 0; s_arburst = 0;
        s_rready = 0;
        for (int i = 0; i < 16; i++) begin wd_v[i] = 32'd0; ws_v[i] = 4'hF; wl_v[i] = 1'b0; end
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_awready", 32'(s_awready), 32'd1);
        check("rst_arready", 32'(s_arready), 32'd1);
        check("rst_wready", 32'(s_wready), 32'd0);
        check("rst_bvalid", 32'(s_bvalid), 32'd0);
        check("rst_rvalid", 32'(s_rvalid), 32'd0);
        check("rst_rlast", 32'(s_rlast), 32'd0);
        check("rst_bresp", 32'(s_bresp), 32'd0);
        check("rst_rresp", 32'(s_rresp), 32'd0);
        check("rst_rdata", s_rdata, 32'd0);
        check("rst_bid", 32'(s_bid), 32'd0);
        check("rst_rid", 32'(s_rid), 32'd0);
        @(posedge clock); #1;

        // single write then read
        wd_v[0] = 32'hDEAD_BEEF; ws_v[0] = 4'hF; wl_v[0] = 1'b1;
        axi_write(4'd3, 32'h8000_0010, 8'd0, 3'd2, 2'b01);
        check("t1_bresp_literal", 32'(last_bresp), 32'd0);
        axi_read(4'd5, 32'h8000_0010, 8'd0, 3'd2, 2'b01, 1'b0, -1);
        check("t1_rdata_literal", last_rdata, 32'hDEAD_BEEF);

        // preload 0x100.. with 1..8, then 4-beat INCR read under toggling rready
        for (int i = 0; i < 8; i++) begin wd_v[i] = 32'(i + 1); ws_v[i] = 4'hF; wl_v[i] = (i == 7); end
        axi_write(4'd1, 32'h8000_0100, 8'd7, 3'd2, 2'b01);
        axi_read(4'd7, 32'h8000_0100, 8'd3, 3'd2, 2'b01, 1'b1, -1);
        check("t2_last_beat_literal", last_rdata, 32'd4);

        // partial strobe
        wd_v[0] = 32'h1122_3344; ws_v[0] = 4'hF; wl_v[0] = 1'b1;
        axi_write(4'd2, 32'h8000_0020, 8'd0, 3'd2, 2'b01);
        wd_v[0] = 32'hAABB_CCDD; ws_v[0] = 4'b0101;
        axi_write(4'd2, 32'h8000_0020, 8'd0, 3'd2, 2'b01);
        check("t3_model_literal", model_mem[8], 32'h11BB_33DD);
        axi_read(4'd4, 32'h8000_0020, 8'd0, 3'd2, 2'b01, 1'b0, -1);
        check("t3_rdata_literal", last_rdata, 32'h11BB_33DD);

        // out of range and WRAP must leave word 0 untouched
        wd_v[0] = 32'hCAFE_F00D; ws_v[0] = 4'hF; wl_v[0] = 1'b1;
        axi_write(4'd0, 32'h8000_0000, 8'd0, 3'd2, 2'b01);
        wd_v[0] = 32'h1234_5678;
        axi_write(4'd6, 32'h8000_4000, 8'd0, 3'd2, 2'b01);
        check("t4_oor_bresp_literal", 32'(last_bresp), 32'd2);
        axi_read(4'd6, 32'h8000_4000, 8'd0, 3'd2, 2'b01, 1'b0, -1);
        check("t4_oor_rdata_literal", last_rdata, 32'd0);
        wd_v[0] = 32'h5555_5555; wd_v[1] = 32'h6666_6666; wl_v[0] = 1'b0; wl_v[1] = 1'b1;
        axi_write(4'd9, 32'h8000_0000, 8'd1, 3'd2, 2'b10);
        check("t4_wrap_bresp_literal", 32'(last_bresp), 32'd2);
        axi_read(4'd9, 32'h8000_0000, 8'd1, 3'd2, 2'b10, 1'b0, -1);
        axi_read(4'd0, 32'h8000_0000, 8'd0, 3'd2, 2'b01, 1'b0, -1);
        check("t4_word0_intact_literal", last_rdata, 32'hCAFE_F00D);

        // early wlast: both beats land, response is SLVERR
        wd_v[0] = 32'h0000_00A0; wd_v[1] = 32'h0000_00A1; wl_v[0] = 1'b1; wl_v[1] = 1'b1;
        axi_write(4'd10, 32'h8000_0030, 8'd1, 3'd2, 2'b01);
        check("t5_wlast_bresp_literal", 32'(last_bresp), 32'd2);
        axi_read(4'd10, 32'h8000_0030, 8'd1, 3'd2, 2'b01, 1'b1, -1);
        check("t5_beat1_literal", last_rdata, 32'h0000_00A1);

        // FIXED burst: only the final beat survives
        wd_v[0] = 32'h111; wd_v[1] = 32'h222; wd_v[2] = 32'h333;
        wl_v[0] = 1'b0; wl_v[1] = 1'b0; wl_v[2] = 1'b1;
        axi_write(4'd11, 32'h8000_0040, 8'd2, 3'd2, 2'b00);
        check("t5_fixed_bresp_literal", 32'(last_bresp), 32'd0);
        axi_read(4'd11, 32'h8000_0040, 8'd2, 3'd2, 2'b00, 1'b0, -1);
        check("t5_fixed_rdata_literal", last_rdata, 32'h333);

        // oversize beat
        wd_v[0] = 32'h7777_7777; wl_v[0] = 1'b1;
        axi_write(4'd12, 32'h8000_0050, 8'd0, 3'd3, 2'b01);
        check("t6_size_bresp_literal", 32'(last_bresp), 32'd2);

        // reset during beat 2 of an 8-beat read, then data still present
        axi_read(4'd13, 32'h8000_0100, 8'd7, 3'd2, 2'b01, 1'b0, 1);
        axi_read(4'd14, 32'h8000_0100, 8'd3, 3'd2, 2'b01, 1'b0, -1);
        check("t7_after_reset_literal", last_rdata, 32'd4);
        axi_read(4'd15, 32'h8000_0010, 8'd0, 3'd2, 2'b01, 1'b0, -1);
        check("t7_deadbeef_literal", last_rdata, 32'hDEAD_BEEF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ysyx_25040111_axi_sram.md
Name: ysyx_25040111_axi_sram

Overview:
AXI4 responder (slave) memory that terminates the core's io_master AXI4 interface in standalone simulation and the bring-up bench.
- Independent read and write channel FSMs, one outstanding transaction per channel.
- Word-addressed internal array; FIXED and INCR bursts up to 256 beats; per-beat address range check.
- Sits opposite the core top: core io_master_* connects to this block's s_* ports.

Parameters:
ADDR_BASE, 32'h8000_0000, byte address mapped to array word 0
MEM_AW, 12, log2 of array depth in 32-bit words (default 4096 words = 16 KiB)
RD_LAT, 2, idle cycles between AR handshake and first rvalid (0..15)

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
s_awready out 1 / s_awvalid in 1 / s_awaddr in 32 / s_awid in 4 / s_awlen in 8 / s_awsize in 3 / s_awburst in 2  write address channel
s_wready out 1 / s_wvalid in 1 / s_wdata in 32 / s_wstrb in 4 / s_wlast in 1  write data channel
s_bready in 1 / s_bvalid out 1 / s_bresp out 2 / s_bid out 4  write response channel
s_arready out 1 / s_arvalid in 1 / s_araddr in 32 / s_arid in 4 / s_arlen in 8 / s_arsize in 3 / s_arburst in 2  read address channel
s_rready in 1 / s_rvalid out 1 / s_rresp out 2 / s_rdata out 32 / s_rlast in→out 1 / s_rid out 4  read data channel (s_rlast is an output)

Behaviour:
- Clock is clock; reset is synchronous, active-high; all state updates on the rising edge of clock.
- Reset values:
  - awready=1, arready=1.
  - wready, bvalid, rvalid, rlast = 0.
  - bresp, rresp, rdata, bid, rid = 0.
  - Both FSMs return to IDLE.
- Reset mid-burst: the burst is abandoned, with no response issued. Array contents are NOT reset.
- Addressing:
  - Word index = (addr - ADDR_BASE) >> 2.
  - A beat is in range iff addr - ADDR_BASE < 4 << MEM_AW.
  - The low two address bits are ignored for the array index.
  - size > 2 makes the transaction SLVERR.
- Burst address update:
  - FIXED (2'b00): address constant for all beats.
  - INCR (2'b01): address += 4 per beat, 32-bit add, no 4 KiB-boundary check.
  - WRAP (2'b10) and reserved (2'b11): the whole transaction is SLVERR, with no array effect.
- Write FSM:
  - W_IDLE: awready=1. On AW handshake, latch id, addr, len, burst, size, and clear the error flag; go to W_DATA next cycle (awready=0).
  - W_DATA: wready=1. Each W handshake writes the bytes selected by wstrb to the current word if the beat is in range and the transaction is legal; otherwise the beat is dropped and the error flag is set. The beat counter increments per beat.
  - Beat count: the transaction ends on beat awlen+1 regardless of wlast. If wlast is 0 on the final beat, or 1 on any earlier beat, the error flag is set.
  - W_RESP: entered the cycle after the final W handshake. bvalid=1, bid=latched id, bresp = error ? 2'b10 : 2'b00. Held stable until bready; on the handshake go to W_IDLE with awready=1 the next cycle.
  - W beats offered before the AW handshake are stalled (wready=0).
- Read FSM:
  - R_IDLE: arready=1. On AR handshake, latch id, addr, len, burst, size; go to R_WAIT with the counter = RD_LAT. If RD_LAT=0, go directly to R_BURST, so rvalid asserts the cycle after the AR handshake.
  - R_WAIT: decrement the counter each cycle; at 0 go to R_BURST.
  - R_BURST: rvalid=1, rid=latched id.
    - In range and legal: rdata = array word, rresp = 2'b00.
    - Otherwise: rdata = 0, rresp = 2'b10.
    - rlast=1 on beat arlen+1.
  - Backpressure: rvalid, rdata, rresp and rlast are held stable while rready=0.
  - After a non-last handshake, the next beat is presented the following cycle (1 beat/cycle throughput).
  - After the last handshake, rvalid=0 and the FSM returns to R_IDLE (arready=1) the next cycle.
- Channel concurrency: read and write FSMs run concurrently. If a write beat commits and a read beat samples the same word in the same cycle, the read returns the pre-write data.
- Array: the write port is byte-enabled. Read data is sampled when a beat becomes valid, or on the cycle after a handshake for the next beat.

Test Plan:
- Single write then read: AW addr=0x8000_0010 len=0 size=2 burst=INCR, W data=0xDEADBEEF strb=4'hF wlast=1 → bresp=00 bid=AW id. AR same addr with RD_LAT=2 → rvalid exactly 3 cycles after the AR handshake, rdata=0xDEADBEEF, rlast=1, rresp=00.
- 4-beat INCR read with backpressure: pre-load words 0x100..0x10C with 1,2,3,4; AR len=3; rready toggles 1,0,1,0… → beats return 1,2,3,4 in order, data stable during stalls, rlast only on the 4th beat, rid constant.
- Partial strobe: word 0x8000_0020 holds 0x11223344; write 0xAABBCCDD with strb=4'b0101 → readback 0x11BB33DD.
- Out of range: with MEM_AW=12, write and read at 0x8000_4000 → bresp=10, rresp=10, rdata=0, array unchanged. A WRAP burst at a legal address also returns SLVERR.
- wlast mismatch: AW len=1, W beats with wlast=1 on beat 1 → both beats accepted, bresp=10. FIXED burst len=2 to 0x8000_0040 → only the final beat's data remains.
- Reset mid-read: assert reset during beat 2 of a len=7 read → the next cycle shows rvalid=0, arready=1, awready=1; previously written array data is intact on a subsequent read.
